// File: rtl/ex_mem_stage_if.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_if : EX-stage bundle, forwarding sources and EX/MEM outputs
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ex_mem_stage_if #(
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  logic             MEM_Stall;
  logic             EX_ALUSrcB;
  logic [3:0]       EX_ALUOp;
  logic [1:0]       EX_RegDst;
  logic             EX_MemWre;
  logic             EX_MemRead;
  logic [1:0]       EX_BranchType;
  logic [1:0]       EX_DBDataSrc;
  logic             EX_RegWre;
  logic [W-1:0]     EX_PCadd4;
  logic [W-1:0]     EX_ReadData1;
  logic [W-1:0]     EX_ReadData2;
  logic [W-1:0]     EX_Immediate32;
  logic [4:0]       EX_sa;
  logic [4:0]       EX_rs;
  logic [4:0]       EX_rt;
  logic [4:0]       EX_rd;
  logic [5:0]       EX_func;
  logic             WB_RegWre;
  logic [4:0]       WB_WriteReg;
  logic [W-1:0]     WB_WriteData;
  logic [W-1:0]     MEM_ALUResult;
  logic [W-1:0]     MEM_WriteData;
  logic [W-1:0]     MEM_PCadd4;
  logic [4:0]       MEM_WriteReg;
  logic             MEM_MemWre;
  logic             MEM_MemRead;
  logic             MEM_RegWre;
  logic [1:0]       MEM_DBDataSrc;
  logic             BranchTaken;
  logic [W-1:0]     BranchTarget;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic [CNT_W-1:0] BranchCount;

  modport master (
    output MEM_Stall, EX_ALUSrcB, EX_ALUOp, EX_RegDst, EX_MemWre, EX_MemRead,
           EX_BranchType, EX_DBDataSrc, EX_RegWre, EX_PCadd4, EX_ReadData1,
           EX_ReadData2, EX_Immediate32, EX_sa, EX_rs, EX_rt, EX_rd, EX_func,
           WB_RegWre, WB_WriteReg, WB_WriteData,
    input  MEM_ALUResult, MEM_WriteData, MEM_PCadd4, MEM_WriteReg, MEM_MemWre,
           MEM_MemRead, MEM_RegWre, MEM_DBDataSrc, BranchTaken, BranchTarget,
           IF_ID_Flush, ID_EX_Flush, BranchCount
  );

  modport slave (
    input  MEM_Stall, EX_ALUSrcB, EX_ALUOp, EX_RegDst, EX_MemWre, EX_MemRead,
           EX_BranchType, EX_DBDataSrc, EX_RegWre, EX_PCadd4, EX_ReadData1,
           EX_ReadData2, EX_Immediate32, EX_sa, EX_rs, EX_rt, EX_rd, EX_func,
           WB_RegWre, WB_WriteReg, WB_WriteData,
    output MEM_ALUResult, MEM_WriteData, MEM_PCadd4, MEM_WriteReg, MEM_MemWre,
           MEM_MemRead, MEM_RegWre, MEM_DBDataSrc, BranchTaken, BranchTarget,
           IF_ID_Flush, ID_EX_Flush, BranchCount
  );
endinterface

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage : execute (forwarding, ALU, branch) plus EX/MEM register
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ex_mem_stage #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  ex_mem_stage_if.slave bus
);
  localparam logic [CNT_W-1:0] c_cntMax = '1;

  logic [W-1:0]     r_memAluResult;
  logic [W-1:0]     r_memWriteData;
  logic [W-1:0]     r_memPcAdd4;
  logic [4:0]       r_memWriteReg;
  logic             r_memMemWre;
  logic             r_memMemRead;
  logic             r_memRegWre;
  logic [1:0]       r_memDbDataSrc;
  logic [CNT_W-1:0] r_branchCount;

  logic             w_memFwdOk;
  logic [W-1:0]     w_memFwdVal;
  logic [W-1:0]     w_fwdA;
  logic [W-1:0]     w_fwdB;
  logic [W-1:0]     w_opB;
  logic             w_slt;
  logic             w_sltu;
  logic signed [W-1:0] w_sra;
  logic [W-1:0]     w_aluResult;
  logic [4:0]       w_writeReg;
  logic             w_branchCond;
  logic             w_branchTaken;
  logic             w_unused;

  // A load result is not ready yet in MEM, so it is never forwarded from there.
  assign w_memFwdOk  = r_memRegWre && (r_memDbDataSrc != 2'b01);
  assign w_memFwdVal = (r_memDbDataSrc == 2'b10) ? r_memPcAdd4 : r_memAluResult;

  always_comb begin
    w_fwdA = bus.EX_ReadData1;
    if (w_memFwdOk && (r_memWriteReg == bus.EX_rs) && (bus.EX_rs != 5'd0))
      w_fwdA = w_memFwdVal;
    else if (bus.WB_RegWre && (bus.WB_WriteReg == bus.EX_rs) && (bus.EX_rs != 5'd0))
      w_fwdA = bus.WB_WriteData;
  end

  always_comb begin
    w_fwdB = bus.EX_ReadData2;
    if (w_memFwdOk && (r_memWriteReg == bus.EX_rt) && (bus.EX_rt != 5'd0))
      w_fwdB = w_memFwdVal;
    else if (bus.WB_RegWre && (bus.WB_WriteReg == bus.EX_rt) && (bus.EX_rt != 5'd0))
      w_fwdB = bus.WB_WriteData;
  end

  assign w_opB  = bus.EX_ALUSrcB ? bus.EX_Immediate32 : w_fwdB;
  assign w_slt  = $signed(w_fwdA) < $signed(w_opB);
  assign w_sltu = w_fwdA < w_opB;
  assign w_sra  = $signed(w_opB) >>> bus.EX_sa;

  always_comb begin
    w_aluResult = '0;
    case (bus.EX_ALUOp)
      4'b0000: w_aluResult = w_fwdA + w_opB;
      4'b0001: w_aluResult = w_fwdA - w_opB;
      4'b0010: w_aluResult = w_fwdA & w_opB;
      4'b0011: w_aluResult = w_fwdA | w_opB;
      4'b0100: w_aluResult = w_fwdA ^ w_opB;
      4'b0101: w_aluResult = ~(w_fwdA | w_opB);
      4'b0110: w_aluResult = {{(W-1){1'b0}}, w_slt};
      4'b0111: w_aluResult = {{(W-1){1'b0}}, w_sltu};
      4'b1000: w_aluResult = w_opB << bus.EX_sa;
      4'b1001: w_aluResult = w_opB >> bus.EX_sa;
      4'b1010: w_aluResult = w_sra;
      4'b1011: w_aluResult = {w_opB[15:0], 16'h0000};
      default: w_aluResult = '0;
    endcase
  end

  always_comb begin
    w_writeReg = 5'd0;
    case (bus.EX_RegDst)
      2'b00:   w_writeReg = bus.EX_rt;
      2'b01:   w_writeReg = bus.EX_rd;
      2'b10:   w_writeReg = 5'd31;
      default: w_writeReg = 5'd0;
    endcase
  end

  always_comb begin
    w_branchCond = 1'b0;
    case (bus.EX_BranchType)
      2'b01:   w_branchCond = (w_fwdA == w_fwdB);
      2'b10:   w_branchCond = (w_fwdA != w_fwdB);
      2'b11:   w_branchCond = !w_fwdA[W-1] && (w_fwdA != '0);
      default: w_branchCond = 1'b0;
    endcase
  end

  // A stalled branch is retried once the stall clears, so it must not redirect now.
  assign w_branchTaken = w_branchCond && !bus.MEM_Stall;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_memAluResult <= '0;
      r_memWriteData <= '0;
      r_memPcAdd4    <= '0;
      r_memWriteReg  <= '0;
      r_memMemWre    <= 1'b0;
      r_memMemRead   <= 1'b0;
      r_memRegWre    <= 1'b0;
      r_memDbDataSrc <= '0;
      r_branchCount  <= '0;
    end else begin
      if (!bus.MEM_Stall) begin
        r_memAluResult <= w_aluResult;
        r_memWriteData <= w_fwdB;
        r_memPcAdd4    <= bus.EX_PCadd4;
        r_memWriteReg  <= w_writeReg;
        r_memMemWre    <= bus.EX_MemWre;
        r_memMemRead   <= bus.EX_MemRead;
        r_memRegWre    <= bus.EX_RegWre;
        r_memDbDataSrc <= bus.EX_DBDataSrc;
      end
      if (w_branchTaken && (r_branchCount != c_cntMax))
        r_branchCount <= r_branchCount + CNT_W'(1);
    end
  end

  assign bus.MEM_ALUResult = r_memAluResult;
  assign bus.MEM_WriteData = r_memWriteData;
  assign bus.MEM_PCadd4    = r_memPcAdd4;
  assign bus.MEM_WriteReg  = r_memWriteReg;
  assign bus.MEM_MemWre    = r_memMemWre;
  assign bus.MEM_MemRead   = r_memMemRead;
  assign bus.MEM_RegWre    = r_memRegWre;
  assign bus.MEM_DBDataSrc = r_memDbDataSrc;
  assign bus.BranchTaken   = w_branchTaken;
  assign bus.BranchTarget  = bus.EX_PCadd4 + {bus.EX_Immediate32[W-3:0], 2'b00};
  assign bus.IF_ID_Flush   = w_branchTaken;
  assign bus.ID_EX_Flush   = w_branchTaken;
  assign bus.BranchCount   = r_branchCount;

  assign w_unused = ^{bus.EX_func, bus.EX_Immediate32[W-1:W-2]};
endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// Directed vector table plus hand-written sequences for ex_mem_stage.
`default_nettype none

module tb_ex_mem_stage;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  ex_mem_stage_if #(.W(32), .CNT_W(16)) bus  ();
  ex_mem_stage_if #(.W(32), .CNT_W(4))  sbus ();

  ex_mem_stage #(.W(32), .CNT_W(16)) dut    (.Clk(Clk), .Reset(Reset), .bus(bus));
  ex_mem_stage #(.W(32), .CNT_W(4))  dutSat (.Clk(Clk), .Reset(Reset), .bus(sbus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic        srcB;
    logic [1:0]  regDst;
    logic [4:0]  sa;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] expRes;
    logic [4:0]  expWr;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clearBus();
    bus.MEM_Stall = 1'b0; bus.EX_ALUSrcB = 1'b0; bus.EX_ALUOp = 4'd0;
    bus.EX_RegDst = 2'd0; bus.EX_MemWre = 1'b0; bus.EX_MemRead = 1'b0;
    bus.EX_BranchType = 2'd0; bus.EX_DBDataSrc = 2'd0; bus.EX_RegWre = 1'b0;
    bus.EX_PCadd4 = 32'd0; bus.EX_ReadData1 = 32'd0; bus.EX_ReadData2 = 32'd0;
    bus.EX_Immediate32 = 32'd0; bus.EX_sa = 5'd0; bus.EX_rs = 5'd0;
    bus.EX_rt = 5'd0; bus.EX_rd = 5'd0; bus.EX_func = 6'd0;
    bus.WB_RegWre = 1'b0; bus.WB_WriteReg = 5'd0; bus.WB_WriteData = 32'd0;
  endtask

  task automatic clearSat();
    sbus.MEM_Stall = 1'b1; sbus.EX_ALUSrcB = 1'b0; sbus.EX_ALUOp = 4'd0;
    sbus.EX_RegDst = 2'd0; sbus.EX_MemWre = 1'b0; sbus.EX_MemRead = 1'b0;
    sbus.EX_BranchType = 2'b01; sbus.EX_DBDataSrc = 2'd0; sbus.EX_RegWre = 1'b0;
    sbus.EX_PCadd4 = 32'd0; sbus.EX_ReadData1 = 32'd0; sbus.EX_ReadData2 = 32'd0;
    sbus.EX_Immediate32 = 32'd0; sbus.EX_sa = 5'd0; sbus.EX_rs = 5'd0;
    sbus.EX_rt = 5'd0; sbus.EX_rd = 5'd0; sbus.EX_func = 6'd0;
    sbus.WB_RegWre = 1'b0; sbus.WB_WriteReg = 5'd0; sbus.WB_WriteData = 32'd0;
  endtask

  task automatic checkCleared(input string tag);
    check({tag, ".aluResult"}, bus.MEM_ALUResult, 32'd0);
    check({tag, ".writeData"}, bus.MEM_WriteData, 32'd0);
    check({tag, ".pcAdd4"}, bus.MEM_PCadd4, 32'd0);
    check({tag, ".writeReg"}, {27'd0, bus.MEM_WriteReg}, 32'd0);
    check({tag, ".ctrl"}, {27'd0, bus.MEM_MemWre, bus.MEM_MemRead, bus.MEM_RegWre,
                           bus.MEM_DBDataSrc}, 32'd0);
    check({tag, ".count"}, {16'd0, bus.BranchCount}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 1'b0, 2'b01, 5'd0, 32'h10, 32'h20, 32'h0, 32'h30, 5'd8};
    vecs[1]  = '{4'b0001, 1'b0, 2'b00, 5'd0, 32'h10, 32'h20, 32'h0, 32'hFFFF_FFF0, 5'd2};
    vecs[2]  = '{4'b0010, 1'b0, 2'b10, 5'd0, 32'hF0F0, 32'hFF00, 32'h0, 32'hF000, 5'd31};
    vecs[3]  = '{4'b0011, 1'b0, 2'b11, 5'd0, 32'hF0F0, 32'hFF00, 32'h0, 32'hFFF0, 5'd0};
    vecs[4]  = '{4'b0100, 1'b0, 2'b01, 5'd0, 32'hF0F0, 32'hFF00, 32'h0, 32'h0FF0, 5'd8};
    vecs[5]  = '{4'b0101, 1'b0, 2'b01, 5'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'd8};
    vecs[6]  = '{4'b0110, 1'b1, 2'b01, 5'd0, 32'hFFFF_FFFF, 32'h7, 32'h1, 32'h1, 5'd8};
    vecs[7]  = '{4'b0111, 1'b1, 2'b01, 5'd0, 32'hFFFF_FFFF, 32'h7, 32'h1, 32'h0, 5'd8};
    vecs[8]  = '{4'b1010, 1'b0, 2'b01, 5'd1, 32'h0, 32'h8000_0000, 32'h0, 32'hC000_0000, 5'd8};
    vecs[9]  = '{4'b1000, 1'b0, 2'b01, 5'd4, 32'h0, 32'h1, 32'h0, 32'h10, 5'd8};
    vecs[10] = '{4'b1001, 1'b0, 2'b01, 5'd4, 32'h0, 32'h8000_0000, 32'h0, 32'h0800_0000, 5'd8};
    vecs[11] = '{4'b1011, 1'b1, 2'b01, 5'd0, 32'h0, 32'h5, 32'h1234, 32'h1234_0000, 5'd8};
    vecs[12] = '{4'b1100, 1'b0, 2'b01, 5'd0, 32'h1234, 32'h5678, 32'h0, 32'h0, 5'd8};

    clearBus();
    clearSat();
    Reset = 1'b0;
    repeat (2) tick();
    checkCleared("reset");
    Reset = 1'b1;

    // Table: rs=1, rt=2, rd=8, no register writes so nothing forwards
    for (int i = 0; i < 13; i++) begin
      clearBus();
      bus.EX_ALUOp = vecs[i].op; bus.EX_ALUSrcB = vecs[i].srcB;
      bus.EX_RegDst = vecs[i].regDst; bus.EX_sa = vecs[i].sa;
      bus.EX_ReadData1 = vecs[i].rd1; bus.EX_ReadData2 = vecs[i].rd2;
      bus.EX_Immediate32 = vecs[i].imm; bus.EX_rs = 5'd1; bus.EX_rt = 5'd2;
      bus.EX_rd = 5'd8; bus.EX_PCadd4 = 32'h1000 + i;
      tick();
      check($sformatf("vec%0d.result", i), bus.MEM_ALUResult, vecs[i].expRes);
      check($sformatf("vec%0d.writeReg", i), {27'd0, bus.MEM_WriteReg}, {27'd0, vecs[i].expWr});
      check($sformatf("vec%0d.writeData", i), bus.MEM_WriteData, vecs[i].rd2);
      check($sformatf("vec%0d.pcAdd4", i), bus.MEM_PCadd4, 32'h1000 + i);
    end

    // Stall holds the register
    clearBus();
    bus.EX_ReadData1 = 32'h10; bus.EX_ReadData2 = 32'h20; bus.EX_RegDst = 2'b01;
    bus.EX_rd = 5'd8; bus.EX_RegWre = 1'b1;
    tick();
    bus.MEM_Stall = 1'b1; bus.EX_ALUOp = 4'b0001; bus.EX_rd = 5'd9;
    bus.EX_RegWre = 1'b0; bus.EX_MemWre = 1'b1;
    repeat (2) tick();
    check("stall.result", bus.MEM_ALUResult, 32'h30);
    check("stall.writeReg", {27'd0, bus.MEM_WriteReg}, 32'd8);
    check("stall.ctrl", {30'd0, bus.MEM_RegWre, bus.MEM_MemWre}, 32'h2);

    // MEM result forwarding beats WB
    clearBus();
    bus.EX_ReadData1 = 32'h10; bus.EX_ReadData2 = 32'h20; bus.EX_rt = 5'd2;
    bus.EX_RegWre = 1'b1;
    tick();
    clearBus();
    bus.EX_rs = 5'd2; bus.EX_rt = 5'd5; bus.EX_ALUSrcB = 1'b1; bus.EX_Immediate32 = 32'd1;
    bus.EX_ReadData1 = 32'h7; bus.WB_RegWre = 1'b1; bus.WB_WriteReg = 5'd2;
    bus.WB_WriteData = 32'h99;
    tick();
    check("fwd.memWins", bus.MEM_ALUResult, 32'h31);
    bus.EX_rs = 5'd0;
    tick();
    check("fwd.rsZero", bus.MEM_ALUResult, 32'h8);
    bus.EX_rs = 5'd2;
    tick();
    check("fwd.wbOnly", bus.MEM_ALUResult, 32'h9A);

    // Load in MEM is not forwarded
    clearBus();
    bus.EX_rt = 5'd2; bus.EX_RegWre = 1'b1; bus.EX_MemRead = 1'b1; bus.EX_DBDataSrc = 2'b01;
    bus.EX_ReadData1 = 32'h40;
    tick();
    check("load.ctrl", {29'd0, bus.MEM_MemRead, bus.MEM_DBDataSrc}, 32'h5);
    clearBus();
    bus.EX_rs = 5'd2; bus.EX_ALUSrcB = 1'b1; bus.EX_Immediate32 = 32'd1; bus.EX_ReadData1 = 32'h7;
    tick();
    check("load.noFwd", bus.MEM_ALUResult, 32'h8);

    // PCadd4 forwarding into store data on the rt path
    clearBus();
    bus.EX_rt = 5'd2; bus.EX_RegWre = 1'b1; bus.EX_DBDataSrc = 2'b10; bus.EX_PCadd4 = 32'h100;
    tick();
    check("pcsrc.ctrl", {29'd0, bus.MEM_RegWre, bus.MEM_DBDataSrc}, 32'h6);
    clearBus();
    bus.EX_rt = 5'd2; bus.EX_ReadData2 = 32'h55; bus.EX_MemWre = 1'b1;
    tick();
    check("fwdPc.result", bus.MEM_ALUResult, 32'h100);
    check("fwdPc.storeData", bus.MEM_WriteData, 32'h100);
    check("fwdPc.memWre", {31'd0, bus.MEM_MemWre}, 32'h1);

    // Branches
    clearBus();
    bus.EX_BranchType = 2'b01; bus.EX_rs = 5'd3; bus.EX_rt = 5'd4;
    bus.EX_ReadData1 = 32'd5; bus.EX_ReadData2 = 32'd5; bus.EX_PCadd4 = 32'h4;
    bus.EX_Immediate32 = 32'hFFFF;
    #1;
    check("beq.taken", {31'd0, bus.BranchTaken}, 32'h1);
    check("beq.target", bus.BranchTarget, 32'h40000);
    check("beq.flush", {30'd0, bus.IF_ID_Flush, bus.ID_EX_Flush}, 32'h3);
    tick();
    check("beq.count", {16'd0, bus.BranchCount}, 32'd1);
    bus.EX_BranchType = 2'b10;
    #1;
    check("bneEq.taken", {31'd0, bus.BranchTaken}, 32'h0);
    tick();
    check("bneEq.count", {16'd0, bus.BranchCount}, 32'd1);
    bus.EX_ReadData2 = 32'd6;
    #1;
    check("bneNe.taken", {31'd0, bus.BranchTaken}, 32'h1);
    bus.EX_BranchType = 2'b11; bus.EX_ReadData1 = 32'd1;
    #1;
    check("bgtzPos.taken", {31'd0, bus.BranchTaken}, 32'h1);
    tick();
    check("bgtz.count", {16'd0, bus.BranchCount}, 32'd2);
    bus.EX_ReadData1 = 32'h8000_0000;
    #1;
    check("bgtzNeg.taken", {31'd0, bus.BranchTaken}, 32'h0);
    bus.EX_ReadData1 = 32'h0;
    #1;
    check("bgtzZero.taken", {31'd0, bus.BranchTaken}, 32'h0);

    // Stalled BEQ does not redirect or count
    bus.EX_BranchType = 2'b01; bus.EX_ReadData1 = 32'd5; bus.EX_ReadData2 = 32'd5;
    bus.MEM_Stall = 1'b1;
    #1;
    check("stallBeq.taken", {31'd0, bus.BranchTaken}, 32'h0);
    check("stallBeq.flush", {30'd0, bus.IF_ID_Flush, bus.ID_EX_Flush}, 32'h0);
    tick();
    check("stallBeq.count", {16'd0, bus.BranchCount}, 32'd2);

    // Asynchronous reset in the middle of a taken branch
    bus.MEM_Stall = 1'b0;
    tick();
    check("preReset.count", {16'd0, bus.BranchCount}, 32'd3);
    check("preReset.result", bus.MEM_ALUResult, 32'd10);
    #2;
    Reset = 1'b0;
    #1;
    checkCleared("asyncReset");
    tick();
    Reset = 1'b1;

    // Saturation on a 4-bit counter instance
    sbus.MEM_Stall = 1'b0;
    repeat (14) tick();
    check("sat.count14", {28'd0, sbus.BranchCount}, 32'd14);
    repeat (6) tick();
    check("sat.hold", {28'd0, sbus.BranchCount}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
